// File: rtl/kbd_pkg.sv
// Shared types and constants for the calculator key matrix scanner.
// The keycode is the column index followed by the row within that column's group.
package kbd_pkg;

    localparam int NUM_COLS       = 11;
    localparam int LEFT_COLS      = 6;
    localparam int ROWS_PER_GROUP = 4;
    localparam int KEYCODE_W      = 6;
    localparam int COL_W          = 4;
    localparam int ROW_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_EVAL
    } scan_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_class_t;

    function automatic logic [KEYCODE_W-1:0] make_keycode(input logic [COL_W-1:0] col,
                                                          input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/kbd_debounce.sv
// Debounces classified scan results into single key events and holds the
// most recent event in a one-entry buffer for the calculator core.
module kbd_debounce
    import kbd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int RELEASE_SCANS  = 4
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 scan_eval,
    input  scan_class_t          scan_class,
    input  logic [KEYCODE_W-1:0] scan_code,
    input  logic                 key_ack_in,
    output logic                 key_valid_o,
    output logic [KEYCODE_W-1:0] key_code_o,
    output logic                 key_down_o,
    output logic                 key_lost_o
);

    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int EMPTY_W = $clog2(RELEASE_SCANS + 1);

    logic [MATCH_W-1:0]   match_q, match_d;
    logic [EMPTY_W-1:0]   empty_q, empty_d;
    logic [KEYCODE_W-1:0] last_code_q, last_code_d;
    logic                 down_q, down_d;
    logic                 valid_q, valid_d;
    logic [KEYCODE_W-1:0] code_q, code_d;
    logic                 lost_q, lost_d;
    logic                 key_event;

    always_comb begin
        match_d     = match_q;
        empty_d     = empty_q;
        last_code_d = last_code_q;
        down_d      = down_q;
        key_event   = 1'b0;

        if (scan_eval) begin
            if (!down_q) begin
                if (scan_class == SCAN_SINGLE) begin
                    if (scan_code == last_code_q && match_q != '0) begin
                        if (match_q != MATCH_W'(DEBOUNCE_SCANS)) begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = MATCH_W'(1);
                    end
                    last_code_d = scan_code;
                    if (match_d == MATCH_W'(DEBOUNCE_SCANS)) begin
                        down_d    = 1'b1;
                        key_event = 1'b1;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                // Any key activity while held restarts the release count.
                if (scan_class == SCAN_NONE) begin
                    if (empty_q == EMPTY_W'(RELEASE_SCANS - 1)) begin
                        down_d  = 1'b0;
                        empty_d = '0;
                        match_d = '0;
                    end else begin
                        empty_d = empty_q + 1'b1;
                    end
                end else begin
                    empty_d = '0;
                end
            end
        end
    end

    // An acknowledge in the same cycle as a new event frees the slot for it.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        lost_d  = 1'b0;

        if (key_event) begin
            if (!valid_q || key_ack_in) begin
                valid_d = 1'b1;
                code_d  = scan_code;
            end else begin
                lost_d = 1'b1;
            end
        end else if (key_ack_in && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            match_q     <= '0;
            empty_q     <= '0;
            last_code_q <= '0;
            down_q      <= 1'b0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            lost_q      <= 1'b0;
        end else begin
            match_q     <= match_d;
            empty_q     <= empty_d;
            last_code_q <= last_code_d;
            down_q      <= down_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            lost_q      <= lost_d;
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign key_down_o  = down_q;
    assign key_lost_o  = lost_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// Column sequencer for the calculator key matrix: drives one column at a time,
// samples its row group after settling, and hands each full scan to the debouncer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no column driven, waiting for enable_in
//   ST_DRIVE | column col_q pulled low, settle counter running
//   ST_EVAL  | one cycle, all columns released, scan result classified
module key_matrix_scanner
    import kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int RELEASE_SCANS  = 4
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 enable_in,
    output logic [NUM_COLS-1:0]  col_drv_o,
    input  logic [7:0]           rows_in,
    output logic                 key_valid_o,
    output logic [KEYCODE_W-1:0] key_code_o,
    input  logic                 key_ack_in,
    output logic                 key_down_o,
    output logic                 key_lost_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);

    scan_state_t          state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     settle_q, settle_d;
    logic [1:0]           hits_q, hits_d;
    logic [KEYCODE_W-1:0] hit_code_q, hit_code_d;

    logic [ROWS_PER_GROUP-1:0] group_low;
    logic [2:0]                low_cnt;
    logic [2:0]                hits_sum;
    logic [ROW_W-1:0]          low_row;
    logic                      settle_done;
    logic [NUM_COLS-1:0]       col_drv;
    scan_class_t               scan_class;

    assign settle_done = (settle_q == CNT_W'(SETTLE_CYCLES - 1));

    always_comb begin
        group_low = (col_q < COL_W'(LEFT_COLS)) ? ~rows_in[3:0] : ~rows_in[7:4];
        low_cnt   = 3'(group_low[0]) + 3'(group_low[1]) + 3'(group_low[2]) + 3'(group_low[3]);
        hits_sum  = {1'b0, hits_q} + low_cnt;
        low_row   = '0;
        for (int r = ROWS_PER_GROUP - 1; r >= 0; r--) begin
            if (group_low[r]) begin
                low_row = ROW_W'(r);
            end
        end
    end

    // hits_q saturates at 2: only "none", "exactly one" and "more" matter.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        settle_d   = settle_q;
        hits_d     = hits_q;
        hit_code_d = hit_code_q;
        col_drv    = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d  = ST_DRIVE;
                    col_d    = '0;
                    settle_d = '0;
                end
            end
            ST_DRIVE: begin
                col_drv[col_q] = 1'b1;
                if (settle_done) begin
                    settle_d = '0;
                    hits_d   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
                    if (low_cnt == 3'd1) begin
                        hit_code_d = make_keycode(col_q, low_row);
                    end
                    if (col_q == COL_W'(NUM_COLS - 1)) begin
                        state_d = ST_EVAL;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_EVAL: begin
                hits_d     = '0;
                hit_code_d = '0;
                col_d      = '0;
                settle_d   = '0;
                state_d    = enable_in ? ST_DRIVE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            settle_q   <= '0;
            hits_q     <= '0;
            hit_code_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            settle_q   <= settle_d;
            hits_q     <= hits_d;
            hit_code_q <= hit_code_d;
        end
    end

    always_comb begin
        case (hits_q)
            2'd0:    scan_class = SCAN_NONE;
            2'd1:    scan_class = SCAN_SINGLE;
            default: scan_class = SCAN_MULTI;
        endcase
    end

    assign col_drv_o = col_drv;

    kbd_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .RELEASE_SCANS (RELEASE_SCANS)
    ) u_debounce (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .scan_eval  (state_q == ST_EVAL),
        .scan_class (scan_class),
        .scan_code  (hit_code_q),
        .key_ack_in (key_ack_in),
        .key_valid_o(key_valid_o),
        .key_code_o (key_code_o),
        .key_down_o (key_down_o),
        .key_lost_o (key_lost_o)
    );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Scan-level bench: a key-matrix board model drives rows_in, and a per-scan
// history model predicts press/release, buffer and loss behaviour.
module tb_key_matrix_scanner;

    localparam int SETTLE  = 4;
    localparam int DEB     = 3;
    localparam int REL     = 2;
    localparam int PERIOD  = 11 * SETTLE + 1;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic [10:0] col_drv_o;
    logic [7:0]  rows_in;
    logic        key_valid_o;
    logic [5:0]  key_code_o;
    logic        key_ack_in;
    logic        key_down_o;
    logic        key_lost_o;

    int checks   = 0;
    int failures = 0;

    bit [3:0]   keys [11];
    int         hist [$];
    bit         m_valid;
    bit         m_down;
    logic [5:0] m_code;

    key_matrix_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB),
        .RELEASE_SCANS (REL)
    ) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .enable_in  (enable_in),
        .col_drv_o  (col_drv_o),
        .rows_in    (rows_in),
        .key_valid_o(key_valid_o),
        .key_code_o (key_code_o),
        .key_ack_in (key_ack_in),
        .key_down_o (key_down_o),
        .key_lost_o (key_lost_o)
    );

    always #5 clk_in = ~clk_in;

    // Physical matrix: a pressed key shorts its row to its column.
    always_comb begin
        rows_in = 8'hFF;
        for (int c = 0; c < 11; c++) begin
            if (col_drv_o[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c][r]) rows_in[(c < 6 ? 0 : 4) + r] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 11; c++) keys[c] = 4'b0000;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_down  = 1'b0;
        m_code  = '0;
        hist.delete();
    endtask

    // -1 = no key, -2 = several keys, otherwise col*4+row
    function automatic int scan_result();
        int n    = 0;
        int code = -1;
        for (int c = 0; c < 11; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c][r]) begin
                    n++;
                    code = c * 4 + r;
                end
        if (n == 0) return -1;
        if (n == 1) return code;
        return -2;
    endfunction

    task automatic model_scan(input int res, input bit ack_eval, output bit lost);
        bit ev  = 1'b0;
        bit all;
        lost = 1'b0;
        hist.push_back(res);
        while (hist.size() > 8) hist.delete(0);
        if (!m_down) begin
            if (res >= 0 && hist.size() >= DEB) begin
                all = 1'b1;
                for (int j = hist.size() - DEB; j < hist.size(); j++)
                    if (hist[j] != res) all = 1'b0;
                if (all) begin
                    ev     = 1'b1;
                    m_down = 1'b1;
                end
            end
        end else if (hist.size() >= REL) begin
            all = 1'b1;
            for (int j = hist.size() - REL; j < hist.size(); j++)
                if (hist[j] != -1) all = 1'b0;
            if (all) m_down = 1'b0;
        end
        if (ev) begin
            if (!m_valid || ack_eval) begin
                m_valid = 1'b1;
                m_code  = 6'(res);
            end else begin
                lost = 1'b1;
            end
        end else if (ack_eval && m_valid) begin
            m_valid = 1'b0;
        end
    endtask

    // ack_mode: 0 none, 1 ack mid-scan, 2 ack during the evaluation cycle.
    // Entered and left on the first cycle of a scan (column 0 driven).
    task automatic run_scan(input int ack_mode);
        int res = scan_result();
        bit lost_exp;
        for (int i = 0; i < PERIOD; i++) begin
            check("col_drv", 32'(col_drv_o), (i < PERIOD - 1) ? (32'd1 << (i / SETTLE)) : 32'd0);
            if (i == 1) check("lost_one_cycle", 32'(key_lost_o), 32'd0);
            if (ack_mode == 1 && i == 21) check("ack_mid_valid", 32'(key_valid_o), 32'd0);
            key_ack_in = (ack_mode == 1 && i == 20) || (ack_mode == 2 && i == PERIOD - 1);
            if (ack_mode == 1 && i == 20) m_valid = 1'b0;
            tick();
        end
        key_ack_in = 1'b0;
        model_scan(res, ack_mode == 2, lost_exp);
        check("key_valid", 32'(key_valid_o), 32'(m_valid));
        check("key_code", 32'(key_code_o), 32'(m_code));
        check("key_down", 32'(key_down_o), 32'(m_down));
        check("key_lost", 32'(key_lost_o), 32'(lost_exp));
    endtask

    initial begin
        int c1, r1, c2, r2, kind, runlen;

        reset_in   = 1'b1;
        enable_in  = 1'b0;
        key_ack_in = 1'b0;
        clear_keys();
        model_reset();
        repeat (3) tick();
        check("rst_col_drv", 32'(col_drv_o), 32'd0);
        check("rst_valid", 32'(key_valid_o), 32'd0);
        check("rst_code", 32'(key_code_o), 32'd0);
        check("rst_down", 32'(key_down_o), 32'd0);
        check("rst_lost", 32'(key_lost_o), 32'd0);
        reset_in  = 1'b0;
        enable_in = 1'b1;
        tick();

        // idle matrix
        repeat (2) run_scan(0);

        // col 3 row 2 held: one event, no repeat
        keys[3][2] = 1'b1;
        repeat (13) run_scan(0);
        check("code_0e", 32'(key_code_o), 32'h0E);
        check("held_valid", 32'(key_valid_o), 32'd1);

        // release with ack, then col 7 row 1
        clear_keys();
        run_scan(1);
        run_scan(0);
        check("released", 32'(key_down_o), 32'd0);
        keys[7][1] = 1'b1;
        repeat (3) run_scan(0);
        check("code_1d", 32'(key_code_o), 32'h1D);

        // two keys: no event until one is dropped
        clear_keys();
        run_scan(1);
        run_scan(0);
        keys[1][0] = 1'b1;
        keys[8][3] = 1'b1;
        repeat (4) run_scan(0);
        check("multi_no_down", 32'(key_down_o), 32'd0);
        keys[8][3] = 1'b0;
        repeat (3) run_scan(0);
        check("code_04", 32'(key_code_o), 32'h04);

        // unacked buffer: second event is lost
        clear_keys();
        repeat (2) run_scan(0);
        c1 = $urandom_range(0, 10);
        r1 = $urandom_range(0, 3);
        keys[c1][r1] = 1'b1;
        repeat (3) run_scan(0);
        check("lost_keeps_code", 32'(key_code_o), 32'h04);

        // ack coinciding with the event loads the new code
        clear_keys();
        repeat (2) run_scan(0);
        c2 = $urandom_range(0, 10);
        r2 = $urandom_range(0, 3);
        keys[c2][r2] = 1'b1;
        repeat (2) run_scan(0);
        run_scan(2);
        check("ack_event_code", 32'(key_code_o), 32'(c2 * 4 + r2));

        // enable dropped mid-scan: scan completes, then idle
        clear_keys();
        enable_in = 1'b0;
        run_scan(0);
        repeat (3) begin
            check("idle_col_drv", 32'(col_drv_o), 32'd0);
            tick();
        end
        enable_in = 1'b1;
        tick();

        // randomized key patterns and acks
        for (int g = 0; g < 14; g++) begin
            clear_keys();
            kind = $urandom_range(0, 3);
            if (kind != 0) keys[$urandom_range(0, 10)][$urandom_range(0, 3)] = 1'b1;
            if (kind == 3) keys[$urandom_range(0, 10)][$urandom_range(0, 3)] = 1'b1;
            runlen = $urandom_range(1, 5);
            for (int s = 0; s < runlen; s++) run_scan($urandom_range(0, 2));
        end

        // reset during column 5
        clear_keys();
        repeat (2) run_scan(1);
        keys[2][1] = 1'b1;
        repeat (3) run_scan(0);
        repeat (21) tick();
        check("pre_rst_col5", 32'(col_drv_o), 32'h020);
        reset_in = 1'b1;
        tick();
        model_reset();
        check("mid_rst_col_drv", 32'(col_drv_o), 32'd0);
        check("mid_rst_valid", 32'(key_valid_o), 32'd0);
        check("mid_rst_code", 32'(key_code_o), 32'd0);
        check("mid_rst_down", 32'(key_down_o), 32'd0);
        check("mid_rst_lost", 32'(key_lost_o), 32'd0);
        reset_in = 1'b0;
        tick();
        check("restart_col0", 32'(col_drv_o), 32'h001);
        repeat (4) run_scan(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Sequences the calculator key matrix: drives the 11 column lines one at a time, samples the row inputs, and debounces the result into single keycode events.
- Sits between the column/row pins and the calculator core's key interface, replacing ad hoc column polling.
- The top level turns the col_drv_o bits into open-drain drives on the inout column pins.

Parameters:
- SETTLE_CYCLES, 64: clock cycles each column is driven before its rows are sampled (>=2).
- DEBOUNCE_SCANS, 4: consecutive identical single-key scans required to accept a press (>=1).
- RELEASE_SCANS, 4: consecutive empty scans required to declare release (>=1).

Ports:
- clk_in, input, 1: system clock.
- reset_in, input, 1: synchronous reset, active-high.
- enable_in, input, 1: scan enable.
- col_drv_o, output, 11: one-hot column drive, 1 = pull column low. Bit order: [0]col0l [1]col1l [2]col2lt [3]col2l [4]col3l [5]col4l [6]col0r [7]col1r [8]col2r [9]col3r [10]col4r.
- rows_in, input, 8: row inputs, active-low. [3:0] = rowsl_in, [7:4] = rowsr_in.
- key_valid_o, output, 1: keycode available, held until acknowledged.
- key_code_o, output, 6: {column[3:0], row[1:0]}.
- key_ack_in, input, 1: consumer acknowledge.
- key_down_o, output, 1: a debounced key is currently held.
- key_lost_o, output, 1: one-cycle pulse; an accepted press was dropped because the buffer was full.

Behaviour:
- Reset: col_drv_o=0, key_valid_o=0, key_code_o=0, key_down_o=0, key_lost_o=0. FSM goes to IDLE, column index 0, all counters 0.
- FSM states: IDLE, DRIVE, EVAL.
  - IDLE: col_drv_o=0. When enable_in=1, go to DRIVE with column 0.
  - DRIVE: col_drv_o=1<<col. A settle counter runs 0..SETTLE_CYCLES-1. On the cycle the counter equals SETTLE_CYCLES-1, sample the active-low rows of that column's group (rows_in[3:0] for col 0-5, rows_in[7:4] for col 6-10) into the scan accumulator. On the next cycle, go to col+1, or to EVAL after col 10.
  - EVAL: one cycle, col_drv_o=0. Classify the scan result, then go to DRIVE col 0 if enable_in=1, else IDLE.
  - Scan period: 11*SETTLE_CYCLES+1 cycles.
- enable_in deasserting mid-scan: the current scan completes through EVAL, then the FSM enters IDLE.
- Scan classification:
  - NONE: zero rows low over all columns.
  - SINGLE: exactly one row low in exactly one column.
  - MULTI: anything else (rollover or ghosting).
- Debounce, pressed side (key_down_o=0):
  - SINGLE with the same code as the previous scan: increment the match counter (saturating).
  - SINGLE with a different code: match counter = 1.
  - NONE or MULTI: match counter = 0.
  - When the counter reaches DEBOUNCE_SCANS: set key_down_o=1 and issue the event.
- Release side (key_down_o=1):
  - NONE: increment the empty counter. At RELEASE_SCANS, clear key_down_o and both counters.
  - SINGLE or MULTI: empty counter = 0.
  - A held key never generates a second event; there is no autorepeat.
- Event buffer (single entry):
  - On an event with key_valid_o=0: load key_code_o, set key_valid_o on the cycle after EVAL.
  - On an event with key_valid_o=1 and no ack that cycle: keep the old code and pulse key_lost_o.
  - key_ack_in while key_valid_o=1 clears key_valid_o on the next cycle. key_code_o holds its value.
  - Ack and event in the same cycle: the new code is loaded and key_valid_o stays 1; no loss.
  - key_ack_in while key_valid_o=0 is ignored.
- Reset mid-scan releases all columns immediately, on the next edge.

Decomposition:
- Shared package kbd_pkg:
  - NUM_COLS=11, LEFT_COLS=6, ROWS_PER_GROUP=4, KEYCODE_W=6.
  - FSM state enum.
  - Scan-class enum {NONE, SINGLE, MULTI}.
  - Function make_keycode(col,row).
- One sub-module, kbd_debounce: owns classification input, the match and empty counters, key_down_o and the event/buffer logic. The top module holds the FSM, settle counter and scan accumulator.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, RELEASE_SCANS=2, scan period 45):
- Reset, enable_in=1, no keys -> col_drv_o steps 0x001, 0x002 … 0x400, each held 4 cycles, then 0x000 for 1 cycle. key_valid_o is never asserted.
- Hold rows_in[2]=0 whenever col_drv_o[3]=1 -> after the 3rd EVAL, key_valid_o=1, key_code_o=0x0E, key_down_o=1. Holding 10 more scans gives no new event.
- Release the key, ack, then hold rows_in[5]=0 on col 7 -> release after 2 empty scans. A new event with key_code_o=0x1D appears after 3 more scans.
- Two keys (col 1 row 0, col 8 row 3) held together -> no event and key_down_o stays 0. Drop one key -> an event appears 3 scans later.
- Leave the first event unacked, release, then press another key -> key_lost_o pulses once and key_code_o keeps the first code. Repeat with key_ack_in on the same cycle -> the new code is loaded and no loss pulse.
- Assert reset_in mid-DRIVE of col 5 -> col_drv_o=0 next cycle, all outputs at reset values, and scanning restarts at col 0.
